// File: rtl/qmath_pkg.sv
// Shared constants and FSM encoding for the sign-magnitude fixed-point arithmetic blocks.
// Both the multiplier and the divider take their defaults from here.
package qmath_pkg;

  localparam int WIDTH    = 31;
  localparam int FBITS    = 16;
  localparam int SIGN_BIT = 31;

  localparam logic [WIDTH:0]   Q_ONE   = (WIDTH+1)'(1) << FBITS;
  localparam logic [WIDTH-1:0] MAG_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } qstate_e;

endpackage

// File: rtl/qsat_round.sv
// Finalisation stage: takes a full-width product magnitude and a sign, then drops the
// fraction bits, saturates and fixes the sign of zero. QMULT_ROUND_EN selects round-half-up.
module qsat_round #(
  parameter int WIDTH = 31,
  parameter int FBITS = 16
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic               sign,
  output logic [WIDTH:0]     product,
  output logic               ovf
);

  localparam logic [2*WIDTH:0] MAG_LIMIT = {{(WIDTH+1){1'b0}}, {WIDTH{1'b1}}};

  // One spare bit so that a rounding carry can still trip the overflow check.
  logic [2*WIDTH:0] rounded;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH-1:0] mag;

`ifdef QMULT_ROUND_EN
  assign rounded = {1'b0, acc} + ((2*WIDTH+1)'(1) << (FBITS-1));
`else
  assign rounded = {1'b0, acc};
`endif

  assign shifted = rounded >> FBITS;

  always_comb begin
    if (shifted > MAG_LIMIT) begin
      mag = '1;
      ovf = 1'b1;
    end else begin
      mag = WIDTH'(shifted);
      ovf = 1'b0;
    end
  end

  assign product = {sign & (|mag), mag};

endmodule

// File: rtl/qmult_seq.sv
// Sequential shift-and-add sign-magnitude multiplier, one multiplier bit per clock.
// Rounding of the dropped fraction bits is enabled by defining QMULT_ROUND_EN.
module qmult_seq #(
  parameter int WIDTH = qmath_pkg::WIDTH,
  parameter int FBITS = qmath_pkg::FBITS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [WIDTH:0] multiplicand,
  input  logic [WIDTH:0] multiplier,
  output logic [WIDTH:0] product,
  output logic           valid,
  output logic           busy,
  output logic           ovf
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

  qmath_pkg::qstate_e state_q, state_d;

  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               sign_q, sign_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     product_q, product_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;

  logic [2*WIDTH-1:0] addend;
  logic [WIDTH:0]     fin_product;
  logic               fin_ovf;

  assign addend = {{WIDTH{1'b0}}, a_mag_q} << cnt_q;

  // Finalisation looks at acc_d so the last partial product lands in the same edge.
  qsat_round #(
    .WIDTH (WIDTH),
    .FBITS (FBITS)
  ) u_fin (
    .acc     (acc_d),
    .sign    (sign_q),
    .product (fin_product),
    .ovf     (fin_ovf)
  );

  always_comb begin
    state_d   = state_q;
    a_mag_d   = a_mag_q;
    b_sh_d    = b_sh_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;

    case (state_q)
      qmath_pkg::IDLE: begin
        if (start) begin
          a_mag_d = multiplicand[WIDTH-1:0];
          b_sh_d  = multiplier[WIDTH-1:0];
          sign_d  = multiplicand[WIDTH] ^ multiplier[WIDTH];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = qmath_pkg::CALC;
        end
      end
      qmath_pkg::CALC: begin
        if (b_sh_q[0]) begin
          acc_d = acc_q + addend;
        end
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          product_d = fin_product;
          ovf_d     = fin_ovf;
          valid_d   = 1'b1;
          state_d   = qmath_pkg::IDLE;
        end
      end
      default: state_d = qmath_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= qmath_pkg::IDLE;
      a_mag_q   <= '0;
      b_sh_q    <= '0;
      sign_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_mag_q   <= a_mag_d;
      b_sh_q    <= b_sh_d;
      sign_q    <= sign_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign product = product_q;
  assign ovf     = ovf_q;
  assign valid   = valid_q;
  assign busy    = (state_q == qmath_pkg::CALC);

endmodule

// File: tb/tb_qmult_seq.sv
// Scoreboard bench for qmult_seq: driver pushes model results, a negedge monitor pops and checks.
// Honours QMULT_ROUND_EN in its reference model.
module tb_qmult_seq;

  localparam int LAT = 31;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic [31:0] product;
  logic        valid;
  logic        busy;
  logic        ovf;

  qmult_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .valid        (valid),
    .busy         (busy),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prod;
    logic        ovf;
    int          e0;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   txn = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Reference: exact integer product of the magnitudes, then drop fraction bits.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] m;
    logic [63:0] mag;
    m = {33'b0, a[30:0]} * {33'b0, b[30:0]};
`ifdef QMULT_ROUND_EN
    m = m + 64'd32768;
`endif
    mag = m >> 16;
    if (mag > 64'h7FFF_FFFF) begin
      e.ovf = 1'b1;
      mag   = 64'h7FFF_FFFF;
    end else begin
      e.ovf = 1'b0;
    end
    e.prod = {(a[31] ^ b[31]) && (mag != 0), mag[30:0]};
    e.e0   = 0;
    return e;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL issue_wait: busy still 1 after %0d cycles, required 0", t);
    end
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e     = model(a, b);
    e.e0  = cyc;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got product %h with no pending request, required none", product);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d: product=%h ovf=%0b expected=%h/%0b latency=%0d busy_cycles=%0d",
                   txn, product, ovf, e.prod, e.ovf, cyc - e.e0, busy_cnt);
          chk("product", product, e.prod);
          chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
          chk("latency", cyc - e.e0, LAT);
          chk("busy_cycles", busy_cnt, LAT);
          chk("busy_in_valid", {31'b0, busy}, 32'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  logic [31:0] ra, rb;
  int          t0;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_product", product, 32'h0);
    chk("reset_valid", {31'b0, valid}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_ovf", {31'b0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases; later ones land in the previous op's valid cycle.
    issue(32'h0001_8000, 32'h0002_0000);
    issue(32'h8001_8000, 32'h0002_0000);
    issue(32'h8001_8000, 32'h8002_0000);
    issue(32'h7FFF_0000, 32'h0002_0000);
    issue(32'h0001_0000, 32'h0001_0000);
    issue(32'h0000_0001, 32'h0000_8000);
    issue(32'h8000_0001, 32'h0000_0001);
    issue(32'h0000_0000, 32'h8000_0000);
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    issue(32'h0000_8000, 32'h0000_8000);

    // Start during busy with different operands must be ignored.
    issue(32'h0003_0000, 32'h8000_4000);
    repeat (9) @(posedge clk);
    #1;
    multiplicand = 32'h7FFF_FFFF;
    multiplier   = 32'h7FFF_FFFF;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      ra[30:0] = ra[30:0] >> $urandom_range(0, 24);
      rb[30:0] = rb[30:0] >> $urandom_range(0, 24);
      issue(ra, rb);
    end

    // Asynchronous reset in the middle of CALC.
    issue(32'h0005_0000, 32'h0003_0000);
    t0 = cyc;
    while (cyc < t0 + 15) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_product", product, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_valid", {31'b0, valid}, 32'd0);
    chk("midrst_ovf", {31'b0, ovf}, 32'd0);
    exp_q.delete();
    busy_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    issue(32'h0002_8000, 32'h8000_C000);
    issue(32'h8010_0000, 32'h8000_0001);

    t0 = 0;
    while (exp_q.size() != 0 && t0 < 200) begin
      @(negedge clk);
      t0++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
